// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM march BIST.
// Each element lists its sweep direction, ops per address, and per-op read flag / data value.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    typedef enum logic [2:0] {
        EL_M0 = 3'd0,
        EL_M1 = 3'd1,
        EL_M2 = 3'd2,
        EL_M3 = 3'd3,
        EL_M4 = 3'd4,
        EL_M5 = 3'd5
    } march_elem_e;

    // Bit [k] of is_read/value describes op k at each address; value selects all-zeros or all-ones.
    typedef struct packed {
        logic       down;
        logic [1:0] n_ops;
        logic [1:0] is_read;
        logic [1:0] value;
    } elem_cfg_t;

    localparam elem_cfg_t ELEM_TABLE [6] = '{
        '{down: 1'b0, n_ops: 2'd1, is_read: 2'b00, value: 2'b00},  // M0 up(w0)
        '{down: 1'b0, n_ops: 2'd2, is_read: 2'b01, value: 2'b10},  // M1 up(r0,w1)
        '{down: 1'b0, n_ops: 2'd2, is_read: 2'b01, value: 2'b01},  // M2 up(r1,w0)
        '{down: 1'b1, n_ops: 2'd2, is_read: 2'b01, value: 2'b10},  // M3 down(r0,w1)
        '{down: 1'b1, n_ops: 2'd2, is_read: 2'b01, value: 2'b01},  // M4 down(r1,w0)
        '{down: 1'b0, n_ops: 2'd1, is_read: 2'b01, value: 2'b00}   // M5 up(r0)
    };

    function automatic march_elem_e next_elem(input march_elem_e elem);
        return (elem == EL_M5) ? EL_M0 : march_elem_e'(elem + 3'd1);
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march BIST with terminal-count flag.
// On a step at terminal count it reloads the start address of the following element.
module sram_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    step_i,
    input  logic                    down_i,
    input  logic                    next_down_i,
    output logic [P_ADDR_WIDTH-1:0] addr_o,
    output logic                    tc_o
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_ADDR_WIDTH-1:0] addr_d;

    assign tc_o   = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign addr_o = addr_q;

    always_comb begin
        // NOTE: addr_d gets a default first so every path assigns it and no latch is inferred.
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (step_i) begin
            if (tc_o) begin
                addr_d = next_down_i ? ADDR_MAX : '0;
            end else if (down_i) begin
                addr_d = addr_q - ADDR_ONE;
            end else begin
                addr_d = addr_q + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving an SRAM BIST port, one op per cycle,
// with a one-stage pipelined read compare and first-fail capture.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_DATA
);

    bist_state_e             state_q;
    march_elem_e             elem_q;
    logic                    op_q;
    logic                    men_q, wen_q, ren_q, val_q;
    logic [P_DATA_WIDTH-1:0] din_q;
    logic                    busy_q, done_q, fail_q;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q;
    logic [P_DATA_WIDTH-1:0] fail_data_q;
    logic                    cmp_vld_q;
    logic [P_DATA_WIDTH-1:0] cmp_exp_q;
    logic [P_ADDR_WIDTH-1:0] cmp_addr_q;

    logic [P_ADDR_WIDTH-1:0] addr;
    logic                    tc;
    logic                    in_run, start_ok, last_op, run_end;
    march_elem_e             nxt_elem;
    logic                    nxt_op, nxt_rd, nxt_val;

    assign in_run   = (state_q == ST_RUN);
    assign start_ok = A_START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_op  = (ELEM_TABLE[elem_q].n_ops == 2'd1) || op_q;
    assign run_end  = in_run && last_op && tc && (elem_q == EL_M5);

    // Position of the op to issue next cycle: second op of a pair, next address, or next element.
    always_comb begin
        nxt_elem = elem_q;
        nxt_op   = 1'b0;
        if (start_ok) begin
            nxt_elem = EL_M0;
        end else if (!last_op) begin
            nxt_op = 1'b1;
        end else if (tc) begin
            nxt_elem = next_elem(elem_q);
        end
        nxt_rd  = ELEM_TABLE[nxt_elem].is_read[nxt_op];
        nxt_val = ELEM_TABLE[nxt_elem].value[nxt_op];
    end

    sram_bist_addr_gen #(
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (A_CLK),
        .rst        (A_RST),
        .clr_i      (start_ok),
        .step_i     (in_run && last_op),
        .down_i     (ELEM_TABLE[elem_q].down),
        .next_down_i(ELEM_TABLE[next_elem(elem_q)].down),
        .addr_o     (addr),
        .tc_o       (tc)
    );

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q     <= ST_IDLE;
            elem_q      <= EL_M0;
            op_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            val_q       <= 1'b0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop here updates from pre-edge values.
            cmp_vld_q <= 1'b0;
            if (cmp_vld_q && (A_DOUT != cmp_exp_q) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
                fail_data_q <= A_DOUT;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q     <= ST_RUN;
                        elem_q      <= nxt_elem;
                        op_q        <= nxt_op;
                        men_q       <= 1'b1;
                        wen_q       <= !nxt_rd;
                        ren_q       <= nxt_rd;
                        val_q       <= nxt_val;
                        din_q       <= nxt_rd ? '0 : {P_DATA_WIDTH{nxt_val}};
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                    end
                end
                ST_RUN: begin
                    cmp_vld_q  <= ren_q;
                    cmp_exp_q  <= {P_DATA_WIDTH{val_q}};
                    cmp_addr_q <= addr;
                    if (run_end) begin
                        state_q <= ST_DRAIN;
                        elem_q  <= EL_M0;
                        op_q    <= 1'b0;
                        men_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ren_q   <= 1'b0;
                        val_q   <= 1'b0;
                        din_q   <= '0;
                    end else begin
                        elem_q <= nxt_elem;
                        op_q   <= nxt_op;
                        men_q  <= 1'b1;
                        wen_q  <= !nxt_rd;
                        ren_q  <= nxt_rd;
                        val_q  <= nxt_val;
                        din_q  <= nxt_rd ? '0 : {P_DATA_WIDTH{nxt_val}};
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A_BIST_EN   = busy_q;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = addr;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = '1;
    assign A_BUSY      = busy_q;
    assign A_DONE      = done_q;
    assign A_FAIL      = fail_q;
    assign A_FAIL_ADDR = fail_addr_q;
    assign A_FAIL_DATA = fail_data_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM model with injectable faults, a March C- op-list
// model checked every cycle, and directed run scenarios with literal expectations.
module tb_sram_march_bist;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int N_OPS = 10 * DEPTH;
    localparam int VW    = 4 + 2 * AW + 3 * DW + 3;

    logic          A_CLK = 1'b0;
    logic          A_RST;
    logic          A_START;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM, A_DOUT;
    logic          A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0] A_FAIL_ADDR;
    logic [DW-1:0] A_FAIL_DATA;

    always #5 A_CLK = ~A_CLK;

    sram_march_bist #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
        .A_CLK      (A_CLK),
        .A_RST      (A_RST),
        .A_START    (A_START),
        .A_BIST_EN  (A_BIST_EN),
        .A_BIST_MEN (A_BIST_MEN),
        .A_BIST_WEN (A_BIST_WEN),
        .A_BIST_REN (A_BIST_REN),
        .A_BIST_ADDR(A_BIST_ADDR),
        .A_BIST_DIN (A_BIST_DIN),
        .A_BIST_BM  (A_BIST_BM),
        .A_DOUT     (A_DOUT),
        .A_BUSY     (A_BUSY),
        .A_DONE     (A_DONE),
        .A_FAIL     (A_FAIL),
        .A_FAIL_ADDR(A_FAIL_ADDR),
        .A_FAIL_DATA(A_FAIL_DATA)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected op stream of a whole run, built straight from the March C- definition.
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;
    op_t ops[$];

    task automatic push_elem(input bit down, input int n, input bit rd_a, input bit val_a, input bit val_b);
        op_t op;
        for (int i = 0; i < DEPTH; i++) begin
            op.addr = down ? AW'(DEPTH - 1 - i) : AW'(i);
            op.wr   = !rd_a;
            op.data = val_a ? '1 : '0;
            ops.push_back(op);
            if (n == 2) begin
                op.wr   = 1'b1;
                op.data = val_b ? '1 : '0;
                ops.push_back(op);
            end
        end
    endtask

    // SRAM: 0 = fault-free, 1 = bit 3 stuck-at-0 at 0x2A, 2 = writing ones to 0x100 flips 0x0FF bit 0.
    int            fault_mode = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wr_data;

    always_comb begin
        wr_data = A_BIST_DIN & A_BIST_BM;
        if (fault_mode == 1 && A_BIST_ADDR == AW'(42)) wr_data[3] = 1'b0;
    end

    always @(posedge A_CLK) begin
        if (A_BIST_MEN && A_BIST_WEN) begin
            mem[A_BIST_ADDR] <= wr_data;
            if (fault_mode == 2 && A_BIST_ADDR == AW'(256) && A_BIST_DIN == '1)
                mem[255][0] <= ~mem[255][0];
        end
        if (A_BIST_MEN && A_BIST_REN) A_DOUT <= mem[A_BIST_ADDR];
    end

    // Run model: position in the op list plus the first-miscompare record.
    typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_e;
    phase_e        phase;
    int            cnt;
    logic          pend;
    logic [DW-1:0] pend_exp;
    logic [AW-1:0] pend_addr;
    logic          m_fail;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fdata;

    always @(posedge A_CLK) begin
        if (A_RST) begin
            phase   <= P_IDLE;
            cnt     <= 0;
            pend    <= 1'b0;
            m_fail  <= 1'b0;
            m_faddr <= '0;
            m_fdata <= '0;
        end else begin
            pend <= 1'b0;
            if (pend && A_DOUT !== pend_exp && !m_fail) begin
                m_fail  <= 1'b1;
                m_faddr <= pend_addr;
                m_fdata <= A_DOUT;
            end
            case (phase)
                P_IDLE, P_DONE: if (A_START) begin
                    phase   <= P_RUN;
                    cnt     <= 0;
                    m_fail  <= 1'b0;
                    m_faddr <= '0;
                    m_fdata <= '0;
                end
                P_RUN: begin
                    if (!ops[cnt].wr) begin
                        pend      <= 1'b1;
                        pend_exp  <= ops[cnt].data;
                        pend_addr <= ops[cnt].addr;
                    end
                    if (cnt == N_OPS - 1) phase <= P_DRAIN;
                    else cnt <= cnt + 1;
                end
                default: phase <= P_DONE;
            endcase
        end
    end

    logic chk_en = 1'b0;

    always @(negedge A_CLK) begin
        logic [VW-1:0] got, exp;
        op_t           op;
        logic          busy;
        if (chk_en) begin
            op   = (phase == P_RUN) ? ops[cnt] : '0;
            busy = (phase == P_RUN) || (phase == P_DRAIN);
            got = {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR,
                   (A_BIST_REN ? {DW{1'b0}} : A_BIST_DIN), A_BIST_BM,
                   A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_DATA};
            exp = {busy, (phase == P_RUN), (phase == P_RUN) && op.wr, (phase == P_RUN) && !op.wr,
                   op.addr, (op.wr ? op.data : {DW{1'b0}}), {DW{1'b1}},
                   busy, (phase == P_DONE), m_fail, m_faddr, m_fdata};
            check("cycle_outputs", 64'(got), 64'(exp));
        end
    end

    // One run: START sampled at edge 0; cycle n is observed at the negedge after edge n-1.
    task automatic do_run(input int extra_start_at, input int abort_at,
                          output int done_cyc, output int busy_cyc, output int fail_cyc,
                          output logic c1_done, output logic c1_fail, output logic c1_busy);
        @(negedge A_CLK);
        A_START = 1'b1;
        @(posedge A_CLK);
        done_cyc = -1;
        busy_cyc = 0;
        fail_cyc = -1;
        c1_done  = 1'b1;
        c1_fail  = 1'b1;
        c1_busy  = 1'b0;
        for (int n = 1; n <= 12000; n++) begin
            @(negedge A_CLK);
            A_START = (n == extra_start_at);
            if (n == 1) begin
                c1_done = A_DONE;
                c1_fail = A_FAIL;
                c1_busy = A_BUSY;
            end
            if (A_BUSY) busy_cyc++;
            if (A_FAIL && fail_cyc < 0) fail_cyc = n;
            if (A_DONE) begin
                done_cyc = n;
                break;
            end
            if (n == abort_at) begin
                A_RST = 1'b1;
                break;
            end
        end
    endtask

    int   done_cyc, busy_cyc, fail_cyc;
    logic c1_done, c1_fail, c1_busy;

    initial begin
        A_RST   = 1'b1;
        A_START = 1'b0;

        push_elem(1'b0, 1, 1'b0, 1'b0, 1'b0);
        push_elem(1'b0, 2, 1'b1, 1'b0, 1'b1);
        push_elem(1'b0, 2, 1'b1, 1'b1, 1'b0);
        push_elem(1'b1, 2, 1'b1, 1'b0, 1'b1);
        push_elem(1'b1, 2, 1'b1, 1'b1, 1'b0);
        push_elem(1'b0, 1, 1'b1, 1'b0, 1'b0);
        check("model_op_count", 64'(ops.size()), 64'(10240));
        check("model_m2_read_2a", 64'(ops[3156]), 64'({1'b0, 10'h02A, 8'hFF}));
        check("model_m3_first", 64'(ops[5120]), 64'({1'b0, 10'h3FF, 8'h00}));
        check("model_last_op", 64'(ops[10239]), 64'({1'b0, 10'h3FF, 8'h00}));

        repeat (3) @(posedge A_CLK);
        @(negedge A_CLK);
        chk_en = 1'b1;
        check("rst_men", 64'(A_BIST_MEN), 64'(0));
        check("rst_busy", 64'(A_BUSY), 64'(0));
        check("rst_done", 64'(A_DONE), 64'(0));
        check("rst_fail", 64'(A_FAIL), 64'(0));
        check("rst_bm", 64'(A_BIST_BM), 64'(8'hFF));
        A_RST = 1'b0;

        // Fault-free run with a second START at cycle 100 that must be ignored.
        do_run(100, 0, done_cyc, busy_cyc, fail_cyc, c1_done, c1_fail, c1_busy);
        check("clean_done_cycle", 64'(done_cyc), 64'(10242));
        check("clean_busy_cycles", 64'(busy_cyc), 64'(10241));
        check("clean_no_fail", 64'(fail_cyc), 64'(-1));
        check("clean_c1_busy", 64'(c1_busy), 64'(1));

        // Stuck-at-0 bit 3 at 0x2A: first hit is the M2 r1 read, issued at cycle 3157.
        fault_mode = 1;
        do_run(0, 0, done_cyc, busy_cyc, fail_cyc, c1_done, c1_fail, c1_busy);
        check("stuck_done_cycle", 64'(done_cyc), 64'(10242));
        check("stuck_fail", 64'(A_FAIL), 64'(1));
        check("stuck_fail_addr", 64'(A_FAIL_ADDR), 64'(10'h02A));
        check("stuck_fail_data", 64'(A_FAIL_DATA), 64'(8'hF7));
        check("stuck_fail_cycle", 64'(fail_cyc), 64'(3159));

        // START from DONE clears DONE/FAIL; reset sampled at edge 500 aborts the run.
        fault_mode = 0;
        do_run(0, 500, done_cyc, busy_cyc, fail_cyc, c1_done, c1_fail, c1_busy);
        check("restart_done_clr", 64'(c1_done), 64'(0));
        check("restart_fail_clr", 64'(c1_fail), 64'(0));
        check("restart_busy", 64'(c1_busy), 64'(1));
        @(negedge A_CLK);
        check("abort_men", 64'(A_BIST_MEN), 64'(0));
        check("abort_busy", 64'(A_BUSY), 64'(0));
        check("abort_fail", 64'(A_FAIL), 64'(0));
        check("abort_done", 64'(A_DONE), 64'(0));
        A_RST = 1'b0;

        do_run(0, 0, done_cyc, busy_cyc, fail_cyc, c1_done, c1_fail, c1_busy);
        check("post_rst_done_cycle", 64'(done_cyc), 64'(10242));
        check("post_rst_busy_cycles", 64'(busy_cyc), 64'(10241));
        check("post_rst_no_fail", 64'(A_FAIL), 64'(0));

        // Coupling fault: 0x0FF reads back 0xFE at the M2 r1 read, issued at cycle 3583.
        fault_mode = 2;
        do_run(0, 0, done_cyc, busy_cyc, fail_cyc, c1_done, c1_fail, c1_busy);
        check("cpl_done_cycle", 64'(done_cyc), 64'(10242));
        check("cpl_fail", 64'(A_FAIL), 64'(1));
        check("cpl_fail_addr", 64'(A_FAIL_ADDR), 64'(10'h0FF));
        check("cpl_fail_data", 64'(A_FAIL_DATA), 64'(8'hFE));
        check("cpl_fail_cycle", 64'(fail_cyc), 64'(3585));

        repeat (2) @(negedge A_CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
